// File: rtl/tm1638_spi_frame.sv
// TM1638 serial master: multi-word frames under one STB assertion, LSB-first,
// with read words sampled from a bidirectional DIO.
module tm1638_spi_frame #(
    parameter int CYCLES     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int STB_GAP    = 2,
    parameter int READ_WAIT  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic                  i_Last,
    input  logic                  i_Read,
    output logic                  o_Rd_Valid,
    output logic [DATA_WIDTH-1:0] o_Rd_Data,
    output logic                  o_Busy,
    output logic                  o_SPI_Stb,
    output logic                  o_SPI_Clk,
    output logic                  o_SPI_Dio_Out,
    output logic                  o_SPI_Dio_Oe,
    input  logic                  i_SPI_Dio,
    output logic [2:0]            o_Diag_State
);
    localparam int BW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int MAX_HP = (READ_WAIT > STB_GAP) ? READ_WAIT : STB_GAP;
    localparam int TW     = $clog2(CYCLES * MAX_HP + 1);

    localparam logic [TW-1:0] T_HP   = TW'(CYCLES - 1);
    localparam logic [TW-1:0] T_WAIT = TW'(CYCLES * READ_WAIT - 1);
    localparam logic [TW-1:0] T_GAP  = TW'(CYCLES * STB_GAP - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4,
        S_WAIT  = 3'd5,
        S_STOP  = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    state_t                  state, state_nx;
    logic [TW-1:0]           timer, timer_nx, t_end;
    logic [BW-1:0]           bit_q, bit_nx;
    logic [DATA_WIDTH-1:0]   data_q, data_nx, rd_shift, rd_shift_nx, rd_data_nx;
    logic                    last_q, last_nx, read_q, read_nx;
    logic                    rd_valid_nx, hp_done;
    logic                    stb_d, clk_d, dout_d, oe_d;

    assign o_Ready      = (state == S_IDLE) || (state == S_HOLD);
    assign o_Busy       = (state != S_IDLE);
    assign o_Diag_State = state;

    always_comb begin
        state_nx    = state;
        bit_nx      = bit_q;
        data_nx     = data_q;
        last_nx     = last_q;
        read_nx     = read_q;
        rd_shift_nx = rd_shift;
        rd_data_nx  = o_Rd_Data;
        rd_valid_nx = 1'b0;

        case (state)
            S_WAIT:  t_end = T_WAIT;
            S_GAP:   t_end = T_GAP;
            default: t_end = T_HP;
        endcase
        hp_done = (timer == t_end);

        case (state)
            S_IDLE, S_HOLD: begin
                if (i_Valid) begin
                    data_nx = i_Data;
                    last_nx = i_Last;
                    read_nx = i_Read;
                    bit_nx  = '0;
                    // Inside an open frame STB is already low, so SETUP is skipped.
                    if (state == S_IDLE) state_nx = S_SETUP;
                    else                 state_nx = i_Read ? S_WAIT : S_LOW;
                end
            end
            S_SETUP: if (hp_done) state_nx = read_q ? S_WAIT : S_LOW;
            S_WAIT:  if (hp_done) state_nx = S_LOW;
            S_LOW: begin
                if (hp_done) begin
                    state_nx = S_HIGH;
                    if (read_q) rd_shift_nx[bit_q] = i_SPI_Dio;
                end
            end
            S_HIGH: begin
                if (hp_done) begin
                    if (bit_q != LAST_BIT) begin
                        bit_nx   = bit_q + 1'b1;
                        state_nx = S_LOW;
                    end else begin
                        if (read_q) begin
                            rd_valid_nx = 1'b1;
                            rd_data_nx  = rd_shift_nx;
                        end
                        state_nx = last_q ? S_STOP : S_HOLD;
                    end
                end
            end
            S_STOP:  if (hp_done) state_nx = S_GAP;
            S_GAP:   if (hp_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        timer_nx = (state_nx != state || state == S_IDLE || state == S_HOLD)
                   ? '0 : timer + 1'b1;

        // Pins are decoded from the next state so they change on the state-entry edge.
        stb_d  = 1'b1;
        clk_d  = 1'b1;
        dout_d = 1'b1;
        oe_d   = 1'b1;
        case (state_nx)
            S_SETUP, S_HOLD, S_STOP: stb_d = 1'b0;
            S_WAIT: begin
                stb_d = 1'b0;
                oe_d  = 1'b0;
            end
            S_LOW, S_HIGH: begin
                stb_d = 1'b0;
                clk_d = (state_nx == S_HIGH);
                oe_d  = ~read_nx;
                if (!read_nx) dout_d = data_nx[bit_nx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            bit_q         <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            read_q        <= 1'b0;
            rd_shift      <= '0;
            o_Rd_Data     <= '0;
            o_Rd_Valid    <= 1'b0;
            o_SPI_Stb     <= 1'b1;
            o_SPI_Clk     <= 1'b1;
            o_SPI_Dio_Out <= 1'b1;
            o_SPI_Dio_Oe  <= 1'b1;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            bit_q         <= bit_nx;
            data_q        <= data_nx;
            last_q        <= last_nx;
            read_q        <= read_nx;
            rd_shift      <= rd_shift_nx;
            o_Rd_Data     <= rd_data_nx;
            o_Rd_Valid    <= rd_valid_nx;
            o_SPI_Stb     <= stb_d;
            o_SPI_Clk     <= clk_d;
            o_SPI_Dio_Out <= dout_d;
            o_SPI_Dio_Oe  <= oe_d;
        end
    end
endmodule

// File: tb/tb_tm1638_spi_frame.sv
// Bench for tm1638_spi_frame: a segment-level timeline model checked every cycle,
// a TM1638 read-back device on DIO, and literal waveform measurements.
module tb_tm1638_spi_frame;
    localparam int C  = 4;
    localparam int W  = 8;
    localparam int G  = 2;
    localparam int RW = 2;

    logic         i_Clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic         i_Valid = 1'b0, i_Last = 1'b0, i_Read = 1'b0, i_SPI_Dio = 1'b1;
    logic [W-1:0] i_Data = '0;
    logic         o_Ready, o_Rd_Valid, o_Busy, o_SPI_Stb, o_SPI_Clk, o_SPI_Dio_Out, o_SPI_Dio_Oe;
    logic [W-1:0] o_Rd_Data;
    logic [2:0]   o_Diag_State;

    tm1638_spi_frame #(.CYCLES(C), .DATA_WIDTH(W), .STB_GAP(G), .READ_WAIT(RW)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_Data(i_Data), .i_Last(i_Last), .i_Read(i_Read),
        .o_Rd_Valid(o_Rd_Valid), .o_Rd_Data(o_Rd_Data), .o_Busy(o_Busy),
        .o_SPI_Stb(o_SPI_Stb), .o_SPI_Clk(o_SPI_Clk), .o_SPI_Dio_Out(o_SPI_Dio_Out),
        .o_SPI_Dio_Oe(o_SPI_Dio_Oe), .i_SPI_Dio(i_SPI_Dio), .o_Diag_State(o_Diag_State)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic stb, clk, oe, dout, rdy, busy, rdv;
        logic [2:0]   st;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t         exp_arr [0:4095];
    int           wp = 0, rp = 0;
    bit           model_on = 1'b1, pend_rdv = 1'b0;
    logic [W-1:0] m_rdata = '0;
    int           vectors = 0, miscompares = 0;

    logic [W-1:0] w_data [4];
    bit           w_read [4];
    logic [W-1:0] dev_word = '0;

    int           stb_low, falls, clk_low, oe_low, hold_rdy, rdv_cnt, stb_hi_run, gap_run, wait_hi;
    logic [W-1:0] cap;
    bit           prev_sclk = 1'b1, prev_oe = 1'b1;
    int           rbit = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Append n cycles of one protocol phase to the expected timeline.
    task automatic seg(int n, logic [2:0] st, logic stb, logic clk, logic oe, logic dout);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.st = st; e.stb = stb; e.clk = clk; e.oe = oe; e.dout = dout;
            e.rdy = (st == 3'd0) || (st == 3'd4);
            e.busy = (st != 3'd0);
            e.rdv = pend_rdv;
            pend_rdv = 1'b0;
            e.rdata = m_rdata;
            exp_arr[wp] = e;
            wp++;
        end
    endtask

    // Timeline of a frame whose words are presented without delay, from the cycle after accept.
    task automatic model_frame(int n);
        logic b;
        seg(C, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < n; k++) begin
            if (w_read[k]) seg(C * RW, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < W; i++) begin
                b = w_read[k] ? 1'b1 : w_data[k][i];
                seg(C, 3'd2, 1'b0, 1'b0, !w_read[k], b);
                seg(C, 3'd3, 1'b0, 1'b1, !w_read[k], b);
            end
            if (w_read[k]) begin
                m_rdata  = dev_word;
                pend_rdv = 1'b1;
            end
            if (k < n - 1) seg(1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1);
            else           seg(C, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        seg(C * G, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        seg(1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic clear_mon();
        stb_low = 0; falls = 0; clk_low = 0; oe_low = 0; hold_rdy = 0;
        rdv_cnt = 0; stb_hi_run = 0; gap_run = 0; wait_hi = 0; cap = '0;
    endtask

    // One clock: compare against the model, update measurements, act as the TM1638 on reads.
    task automatic tick();
        exp_t e;
        @(negedge i_Clk);
        if (!model_on) rp = wp;
        else if (rp < wp) begin
            e = exp_arr[rp];
            vectors++;
            if ({o_SPI_Stb, o_SPI_Clk, o_SPI_Dio_Oe, o_Ready, o_Busy, o_Rd_Valid, o_Diag_State, o_Rd_Data}
                !== {e.stb, e.clk, e.oe, e.rdy, e.busy, e.rdv, e.st, e.rdata}
                || (e.oe && o_SPI_Dio_Out !== e.dout)) begin
                miscompares++;
                $display("FAIL timeline entry %0d: got stb=%b clk=%b oe=%b dout=%b rdy=%b busy=%b rdv=%b st=%0d rd=%h, required stb=%b clk=%b oe=%b dout=%b rdy=%b busy=%b rdv=%b st=%0d rd=%h",
                         rp, o_SPI_Stb, o_SPI_Clk, o_SPI_Dio_Oe, o_SPI_Dio_Out, o_Ready, o_Busy, o_Rd_Valid,
                         o_Diag_State, o_Rd_Data, e.stb, e.clk, e.oe, e.dout, e.rdy, e.busy, e.rdv, e.st, e.rdata);
            end
            rp++;
        end
        if (o_SPI_Stb) stb_hi_run++;
        else begin
            if (stb_hi_run > 0) gap_run = stb_hi_run;
            stb_hi_run = 0;
            stb_low++;
        end
        if (prev_sclk && !o_SPI_Clk) begin
            falls++;
            cap = {o_SPI_Dio_Out, cap[W-1:1]};
        end
        if (!o_SPI_Clk) clk_low++;
        if (!o_SPI_Dio_Oe) oe_low++;
        if (o_Ready && o_Busy) hold_rdy++;
        if (o_Rd_Valid) rdv_cnt++;
        if (prev_oe && !o_SPI_Dio_Oe) rbit = 0;
        if (prev_sclk && !o_SPI_Clk && !o_SPI_Dio_Oe && rbit < W) begin
            i_SPI_Dio = dev_word[rbit];
            rbit++;
        end
        if (!o_SPI_Dio_Oe && o_SPI_Clk && rbit == 0) wait_hi++;
        prev_sclk = o_SPI_Clk;
        prev_oe   = o_SPI_Dio_Oe;
    endtask

    task automatic run_frame(int n, bit keep_valid);
        int to;
        for (int k = 0; k < n; k++) begin
            i_Valid = 1'b1; i_Data = w_data[k]; i_Last = (k == n - 1); i_Read = w_read[k];
            to = 0;
            while (!o_Ready && to < 2000) begin
                tick();
                to++;
            end
            if (!o_Ready) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_timeout word %0d: o_Ready=0 after %0d cycles, required 1", k, to);
                i_Valid = 1'b0;
                return;
            end
            if (k == 0) model_frame(n);
            tick();
        end
        if (!keep_valid) i_Valid = 1'b0;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while (rp < wp && to < 3000) begin
            tick();
            to++;
        end
        if (rp < wp) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d entries left, required 0", wp - rp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        clear_mon();
        for (int k = 0; k < 4; k++) begin w_data[k] = '0; w_read[k] = 1'b0; end

        // Reset values while reset is held, then after release.
        #12;
        chk("rst_stb", o_SPI_Stb, 1);
        chk("rst_clk", o_SPI_Clk, 1);
        chk("rst_dout", o_SPI_Dio_Out, 1);
        chk("rst_oe", o_SPI_Dio_Oe, 1);
        chk("rst_busy", o_Busy, 0);
        chk("rst_rdv", o_Rd_Valid, 0);
        chk("rst_rdata", o_Rd_Data, 0);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        tick();
        chk("rel_ready", o_Ready, 1);
        chk("rel_busy", o_Busy, 0);
        chk("rel_diag", o_Diag_State, 0);
        chk("rel_stb", o_SPI_Stb, 1);

        // Single write 0x44 closing the frame.
        clear_mon();
        w_data[0] = 8'h44; w_read[0] = 1'b0;
        run_frame(1, 1'b0);
        drain();
        chk("w44_stb_low", stb_low, 72);
        chk("w44_falls", falls, 8);
        chk("w44_clk_low", clk_low, 32);
        chk("w44_bits", cap, 8'h44);
        chk("w44_rdv", rdv_cnt, 0);

        // Two-word write frame 0x40, 0xC0.
        clear_mon();
        w_data[0] = 8'h40; w_data[1] = 8'hC0; w_read[1] = 1'b0;
        run_frame(2, 1'b0);
        drain();
        chk("fr2_stb_low", stb_low, 137);
        chk("fr2_falls", falls, 16);
        chk("fr2_hold_ready", hold_rdy, 1);
        chk("fr2_last_bits", cap, 8'hC0);

        // Write 0x42 then read back 0xA5 in the same frame.
        clear_mon();
        w_data[0] = 8'h42; w_read[0] = 1'b0; w_read[1] = 1'b1; dev_word = 8'hA5;
        run_frame(2, 1'b0);
        drain();
        chk("rd_data", o_Rd_Data, 8'hA5);
        chk("rd_valid_pulses", rdv_cnt, 1);
        chk("rd_wait_high", wait_hi, 8);
        chk("rd_oe_low", oe_low, 72);
        chk("rd_oe_after", o_SPI_Dio_Oe, 1);
        w_read[1] = 1'b0;

        // Reset during bit 3 of a write aborts immediately.
        model_on = 1'b0;
        clear_mon();
        w_data[0] = 8'h3C;
        run_frame(1, 1'b0);
        to = 0;
        while (falls < 4 && to < 500) begin tick(); to++; end
        chk("abort_reached_bit3", falls, 4);
        #3;
        i_Rst = 1'b1;
        #1;
        chk("abort_stb", o_SPI_Stb, 1);
        chk("abort_clk", o_SPI_Clk, 1);
        chk("abort_busy", o_Busy, 0);
        chk("abort_rdv", o_Rd_Valid, 0);
        chk("abort_diag", o_Diag_State, 0);
        tick();
        i_Rst = 1'b0;
        m_rdata = '0;
        chk("abort_rdata", o_Rd_Data, 0);
        chk("abort_rdv_cnt", rdv_cnt, 0);
        model_on = 1'b1;

        // Next word after the abort starts with a full SETUP.
        clear_mon();
        w_data[0] = 8'hA1;
        run_frame(1, 1'b0);
        drain();
        chk("post_rst_stb_low", stb_low, 72);
        chk("post_rst_bits", cap, 8'hA1);

        // Back-to-back frames with i_Valid held throughout.
        clear_mon();
        w_data[0] = 8'h11;
        run_frame(1, 1'b1);
        w_data[0] = 8'h22;
        run_frame(1, 1'b0);
        drain();
        chk("b2b_gap_ge8", gap_run >= 8, 1);
        chk("b2b_stb_low", stb_low, 144);
        chk("b2b_falls", falls, 16);
        chk("b2b_bits", cap, 8'h22);

        tick();
        chk("end_idle_diag", o_Diag_State, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
